// File: rtl/if_id_fetch_queue.sv
// Fetch-to-decode decoupling queue: DEPTH-entry circular buffer of {pc, instr}
// pairs with valid/ready handshakes, single-cycle flush and a clock-gating hint.
module if_id_fetch_queue #(
    parameter int unsigned     DEPTH = 4,
    parameter int unsigned     XLEN  = 32,
    parameter logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [XLEN-1:0]              in_instr,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [XLEN-1:0]              out_pc,
    output logic [XLEN-1:0]              out_instr,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         idle
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    // Handshake qualification; flush blocks both the incoming entry and the pop.
    always_comb begin
        w_empty   = (r_count == CW'(0));
        w_full    = (r_count == CW'(DEPTH));
        in_ready  = !w_full;
        out_valid = !w_empty && !flush;
        w_push    = in_valid && in_ready && !flush;
        w_pop     = out_valid && out_ready;
        idle      = w_empty && !in_valid;
        count     = r_count;
    end

    // Head entry is read combinationally; empty queue presents pc 0 / NOP.
    always_comb begin
        out_pc    = '0;
        out_instr = NOP;
        if (!w_empty) begin
            out_pc    = r_pc_mem[r_rd_ptr];
            out_instr = r_instr_mem[r_rd_ptr];
        end
    end

    // Pointer and occupancy update; reset dominates flush.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed self-checking bench for the fetch/decode queue.
module tb_if_id_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic                   in_valid;
    logic [XLEN-1:0]        in_pc;
    logic [XLEN-1:0]        in_instr;
    logic                   in_ready;
    logic                   out_valid;
    logic [XLEN-1:0]        out_pc;
    logic [XLEN-1:0]        out_instr;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   idle;

    int n_checks = 0;
    int n_pass   = 0;

    if_id_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hA5A5, pc[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr_of(pc);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain_chk(input logic [31:0] pc);
        out_ready = 1'b1;
        #1;
        chk("drain_valid", 32'(out_valid), 32'd1);
        chk("drain_pc", out_pc, pc);
        chk("drain_instr", out_instr, instr_of(pc));
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        // reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, NOP);
        chk("rst_idle", 32'(idle), 32'd1);

        // 1: three pushes, no pops
        push(32'h0); push(32'h4); push(32'h8);
        #1;
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_pc", out_pc, 32'h0);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        chk("t1_idle", 32'(idle), 32'd0);

        // 2: fill, overflow attempt ignored, drain in order
        push(32'hC);
        #1;
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        push(32'h10);
        #1;
        chk("t2_count_after_5th", 32'(count), 32'd4);
        drain_chk(32'h0); drain_chk(32'h4); drain_chk(32'h8); drain_chk(32'hC);
        #1;
        chk("t2_empty_valid", 32'(out_valid), 32'd0);
        chk("t2_empty_instr", out_instr, NOP);
        chk("t2_empty_pc", out_pc, 32'd0);
        chk("t2_empty_count", 32'(count), 32'd0);

        // 3: streaming push+pop every cycle
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_pc    = 32'h100 + 32'(4 * k);
            in_instr = instr_of(in_pc);
            #1;
            if (k == 0) begin
                chk("t3_first_valid", 32'(out_valid), 32'd0);
                chk("t3_idle_busy", 32'(idle), 32'd0);
            end else begin
                chk("t3_stream_pc", out_pc, 32'h100 + 32'(4 * (k - 1)));
                chk("t3_stream_count", 32'(count), 32'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("t3_last_pc", out_pc, 32'h11C);
        tick();
        out_ready = 1'b0;
        #1;
        chk("t3_final_count", 32'(count), 32'd0);

        // 4: flush with incoming entry
        push(32'h20); push(32'h24); push(32'h28);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40; in_instr = instr_of(32'h40);
        out_ready = 1'b1;
        #1;
        chk("t4_flush_out_valid", 32'(out_valid), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("t4_count_after_flush", 32'(count), 32'd0);
        chk("t4_valid_after_flush", 32'(out_valid), 32'd0);
        push(32'h80);
        #1;
        chk("t4_target_count", 32'(count), 32'd1);
        drain_chk(32'h80);

        // 5: full with simultaneous push+pop: only the pop happens
        push(32'h200); push(32'h204); push(32'h208); push(32'h20C);
        in_valid = 1'b1; in_pc = 32'h210; in_instr = instr_of(32'h210);
        out_ready = 1'b1;
        #1;
        chk("t5_full_in_ready", 32'(in_ready), 32'd0);
        chk("t5_full_head", out_pc, 32'h200);
        tick();
        out_ready = 1'b0;
        #1;
        chk("t5_count_after_pop", 32'(count), 32'd3);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t5_count_refill", 32'(count), 32'd4);
        drain_chk(32'h204); drain_chk(32'h208); drain_chk(32'h20C); drain_chk(32'h210);
        // pointer wrap over two more full rounds
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push(32'h300 + 32'(16 * r + 4 * k));
            for (int k = 0; k < 4; k++) drain_chk(32'h300 + 32'(16 * r + 4 * k));
        end

        // 6: reset mid-operation (together with flush)
        push(32'h400); push(32'h404);
        #1;
        chk("t6_count_pre", 32'(count), 32'd2);
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_idle", 32'(idle), 32'd1);
        chk("t6_out_instr", out_instr, NOP);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
